// File: rtl/button_conditioner.sv
// Push-button conditioner: synchroniser, press/release debouncer and auto-repeat
// pulse generator feeding the colour-sequencer button input.
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(RPT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1'b1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   btn_s;
  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [TMR_W-1:0]       tmr_r;
  logic                   rpt_phase_r;   // 0: waiting REPEAT_DELAY, 1: REPEAT_PERIOD
  logic                   level_r;
  logic                   press_r;
  logic                   release_r;
  logic                   repeat_r;

  assign btn_s         = sync_r[SYNC_STAGES-1];
  assign level         = level_r;
  assign press         = press_r;
  assign release_pulse = release_r;
  assign repeat_pulse  = repeat_r;

  // Shift the asynchronous pin through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], button_raw};
    end
  end

  // Debounce FSM with repeat timer; every output is a flop updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      tmr_r       <= '0;
      rpt_phase_r <= 1'b0;
      level_r     <= 1'b0;
      press_r     <= 1'b0;
      release_r   <= 1'b0;
      repeat_r    <= 1'b0;
    end else begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      repeat_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          level_r     <= 1'b0;
          tmr_r       <= '0;
          rpt_phase_r <= 1'b0;
          if (btn_s) begin
            state_r <= PRESS_WAIT;
            cnt_r   <= CNT_ONE;
          end else begin
            cnt_r <= '0;
          end
        end
        PRESS_WAIT: begin
          tmr_r       <= '0;
          rpt_phase_r <= 1'b0;
          if (!btn_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= HELD;
            cnt_r   <= '0;
            level_r <= 1'b1;
            press_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state_r <= RELEASE_WAIT;
            cnt_r   <= CNT_ONE;
            if (!repeat_en) begin
              tmr_r       <= '0;
              rpt_phase_r <= 1'b0;
            end
          end else if (!repeat_en) begin
            tmr_r       <= '0;
            rpt_phase_r <= 1'b0;
          end else if (tmr_r == (rpt_phase_r ? PERIOD_LAST : DELAY_LAST)) begin
            repeat_r    <= 1'b1;
            tmr_r       <= '0;
            rpt_phase_r <= 1'b1;
          end else begin
            tmr_r <= tmr_r + TMR_ONE;
          end
        end
        RELEASE_WAIT: begin
          // Timer is frozen here; it only runs while the button stays held.
          if (!repeat_en) begin
            tmr_r       <= '0;
            rpt_phase_r <= 1'b0;
          end
          if (btn_s) begin
            state_r <= HELD;
            cnt_r   <= '0;
          end else if (cnt_r == CNT_LAST) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            tmr_r       <= '0;
            rpt_phase_r <= 1'b0;
            level_r     <= 1'b0;
            release_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= '0;
          tmr_r       <= '0;
          rpt_phase_r <= 1'b0;
          level_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulses are queued with the
// clock edge they should follow; a negedge monitor pops and compares them.
module tb_button_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int DLY  = 8;
  localparam int PER  = 4;
  localparam int LAT  = SYNC + DEB;

  localparam logic [2:0] K_PRESS = 3'b100;
  localparam logic [2:0] K_REL   = 3'b010;
  localparam logic [2:0] K_RPT   = 3'b001;

  logic clk;
  logic reset;
  logic button_raw;
  logic repeat_en;
  logic level;
  logic press;
  logic release_pulse;
  logic repeat_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         at;
    logic [2:0] kind;
    logic       lvl;
  } ev_t;

  ev_t exp_q[$];

  button_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_raw   (button_raw),
    .repeat_en    (repeat_en),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int at, input logic [2:0] kind, input logic lvl);
    ev_t e;
    e.at   = at;
    e.kind = kind;
    e.lvl  = lvl;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_until(input int c);
    while (cyc < c) tick(1);
  endtask

  // Monitor: every pulse the DUT shows must match the head of the queue.
  always @(negedge clk) begin
    ev_t e;
    if ({press, release_pulse, repeat_pulse} != 3'b000) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got kind=%b at edge %0d, expected none",
                 {press, release_pulse, repeat_pulse}, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_edge", cyc, e.at);
        check("pulse_kind", int'({press, release_pulse, repeat_pulse}), int'(e.kind));
        check("pulse_level", int'(level), int'(e.lvl));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int t0;
    reset      = 1'b1;
    button_raw = 1'b0;
    repeat_en  = 1'b0;
    tick(3);
    reset = 1'b0;
    check("reset_outputs", int'({level, press, release_pulse, repeat_pulse}), 0);
    tick(2);

    // Clean press with repeat disabled, held for 20 cycles.
    c = cyc;
    button_raw = 1'b1;
    push(c + LAT, K_PRESS, 1'b1);
    tick_until(c + LAT - 1);
    check("level_before_press", int'(level), 0);
    tick(1);
    check("level_at_press", int'(level), 1);
    tick(20);

    // Clean release.
    c = cyc;
    button_raw = 1'b0;
    push(c + LAT, K_REL, 1'b0);
    tick(10);
    check("level_after_release", int'(level), 0);

    // Bounce on press: 3 high, 1 low, 3 high, low.
    button_raw = 1'b1; tick(3);
    button_raw = 1'b0; tick(1);
    button_raw = 1'b1; tick(3);
    button_raw = 1'b0; tick(10);
    check("level_after_press_bounce", int'(level), 0);

    // Press, then the same bounce pattern on release.
    c = cyc;
    button_raw = 1'b1;
    push(c + LAT, K_PRESS, 1'b1);
    tick(12);
    button_raw = 1'b0; tick(3);
    button_raw = 1'b1; tick(1);
    button_raw = 1'b0; tick(3);
    button_raw = 1'b1; tick(10);
    check("level_after_release_bounce", int'(level), 1);
    c = cyc;
    button_raw = 1'b0;
    push(c + LAT, K_REL, 1'b0);
    tick(10);

    // Auto-repeat: pulses at t0+8, +12, +16, +20.
    repeat_en = 1'b1;
    c = cyc;
    button_raw = 1'b1;
    t0 = c + LAT;
    push(t0, K_PRESS, 1'b1);
    push(t0 + 8,  K_RPT, 1'b1);
    push(t0 + 12, K_RPT, 1'b1);
    push(t0 + 16, K_RPT, 1'b1);
    push(t0 + 20, K_RPT, 1'b1);
    tick_until(t0 + 20);
    button_raw = 1'b0;
    push(t0 + 20 + LAT, K_REL, 1'b0);
    tick(12);

    // repeat_en low for cycles t0+10..t0+11 restarts the delay phase.
    c = cyc;
    button_raw = 1'b1;
    t0 = c + LAT;
    push(t0, K_PRESS, 1'b1);
    push(t0 + 8, K_RPT, 1'b1);
    tick_until(t0 + 10);
    repeat_en = 1'b0;
    tick_until(t0 + 12);
    repeat_en = 1'b1;
    push(t0 + 20, K_RPT, 1'b1);
    push(t0 + 24, K_RPT, 1'b1);
    tick_until(t0 + 24);
    button_raw = 1'b0;
    push(t0 + 24 + LAT, K_REL, 1'b0);
    tick(12);

    // Reset while held: no release, then a fresh full-latency press.
    repeat_en = 1'b0;
    c = cyc;
    button_raw = 1'b1;
    push(c + LAT, K_PRESS, 1'b1);
    tick_until(c + LAT + 4);
    check("level_before_reset", int'(level), 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    c = cyc;
    check("outputs_after_reset", int'({level, press, release_pulse, repeat_pulse}), 0);
    push(c + LAT, K_PRESS, 1'b1);
    tick_until(c + LAT - 1);
    check("level_before_repress", int'(level), 0);
    tick(4);
    check("level_after_repress", int'(level), 1);
    c = cyc;
    button_raw = 1'b0;
    push(c + LAT, K_REL, 1'b0);
    tick(12);

    check("events_outstanding", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Conditions a raw mechanical push-button into clean, glitch-free control signals for the RGB colour-sequencer FSM, which advances on a single-cycle button pulse.
- Synchronises the asynchronous pin into the clk domain.
- Debounces press and release with a consecutive-sample counter.
- Emits one-cycle press and release pulses, plus optional auto-repeat pulses while the button is held.
- Sits directly upstream of the sequencer: press (OR repeat) drives its button input.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on button_raw (>=2).
DEBOUNCE_CYCLES, 16, consecutive stable samples needed to accept a press or release (>=2).
REPEAT_DELAY, 64, cycles from the press pulse to the first repeat pulse (>=2).
REPEAT_PERIOD, 16, cycles between subsequent repeat pulses (>=1).

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
button_raw  input  1  asynchronous raw button pin; 1 = pressed.
repeat_en  input  1  enables auto-repeat pulses while held.
level  output  1  debounced button level.
press  output  1  one-cycle pulse when a press is accepted.
release_pulse  output  1  one-cycle pulse when a release is accepted.
repeat_pulse  output  1  one-cycle auto-repeat pulse while held.

Behaviour:
- One clock and one reset only. Reset is synchronous and active-high: reset sampled high at a posedge clears every flop.
- Reset values:
  - Synchroniser flops = 0, state = IDLE, counters = 0.
  - level, press, release_pulse and repeat_pulse are all 0.
- All outputs are registered. No combinational path from any input to any output.
- Synchroniser: btn_s is the last of SYNC_STAGES flops. btn_s lags button_raw by SYNC_STAGES edges.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES+1). Repeat timer width is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1). Neither counter ever wraps.
- FSM states and transitions:
  - IDLE (level=0): btn_s=1 -> PRESS_WAIT, cnt<=1.
  - PRESS_WAIT (level=0):
    - btn_s=0 -> IDLE. Bounce rejected, no pulse.
    - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, and press=1 for the next cycle.
    - Otherwise cnt++.
  - HELD (level=1): btn_s=0 -> RELEASE_WAIT, cnt<=1.
  - RELEASE_WAIT (level=1):
    - btn_s=1 -> HELD. Bounce rejected, no pulse.
    - btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, with release_pulse=1 and level=0 in the same next cycle.
    - Otherwise cnt++.
- Press latency: button_raw goes high before edge 1 and stays high -> press is high in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES. level rises in that same cycle.
- Release latency is symmetric to press latency.
- Auto-repeat:
  - Let t0 be the cycle in which press=1. The timer starts at 0 in t0.
  - With repeat_en=1 continuously, repeat_pulse=1 at t0+REPEAT_DELAY, then every REPEAT_PERIOD cycles thereafter.
  - The timer freezes in RELEASE_WAIT and resumes on return to HELD. No repeat_pulse is emitted in RELEASE_WAIT.
  - repeat_en=0: timer held at 0 and phase returns to delay phase, so the next repeat comes REPEAT_DELAY cycles after repeat_en returns high. Applies in any state.
  - Leaving to IDLE clears the timer and the phase.
- Mutual exclusion: press, release_pulse and repeat_pulse are never high in the same cycle. A pulse never lasts more than one cycle.
- Reset mid-operation:
  - Reset during HELD emits no release_pulse.
  - If the button is still pressed after reset, a full debounce occurs and a new press pulse is emitted.

Test Plan:
- Clean press, SYNC_STAGES=2, DEBOUNCE_CYCLES=4: button_raw 0->1 before edge 1, held -> press=1 only in the cycle after edge 6; level=1 from that cycle; no other pulses.
- Bounce reject: button_raw high 3 cycles, low 1, high 3, low -> press never asserts, level stays 0. Same glitch pattern on release while HELD -> no release_pulse, level stays 1.
- Clean release after a held press -> release_pulse=1 for exactly one cycle DEBOUNCE_CYCLES+SYNC_STAGES edges after button_raw falls; level=0 in the same cycle.
- Auto-repeat, REPEAT_DELAY=8, REPEAT_PERIOD=4, repeat_en=1, button held 20 cycles past t0 -> repeat_pulse at t0+8, t0+12, t0+16, t0+20. With repeat_en=0 -> no repeat_pulse.
- repeat_en toggled 0 at t0+10 and back to 1 at t0+12 -> next repeat_pulse at t0+20.
- Reset asserted while HELD -> all outputs 0 the next cycle, no release_pulse. Button still high after reset deasserts -> new press after the full SYNC+DEBOUNCE latency.
